// File: rtl/chacha_block_ctrl_if.sv
// chacha_block_ctrl_if: keystream word stream between the ChaCha block
// controller and its consumer.
//
// Signals:
//   out_valid - producer has a word on out_data
//   out_ready - consumer accepts the word on this edge when out_valid is high
//   out_data  - 32-bit keystream word (words 0..15 of one block, in order)
//   out_last  - high only while word 15 of the block is presented
//
// Modports:
//   master - the keystream producer (chacha_block_ctrl)
//   slave  - the keystream consumer
interface chacha_block_ctrl_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/chacha_block_ctrl.sv
// chacha_block_ctrl: iterative ChaCha keystream block generator.
//
// One start pulse in IDLE loads the 16-word ChaCha state from the key, nonce
// and block counter, runs ROUNDS rounds as 4*ROUNDS single quarter-round
// steps through one shared quarter-round datapath, adds the initial state
// back in, then streams the 16 result words with a valid/ready handshake.
//
// Parameters:
//   ROUNDS     - total ChaCha rounds; must be even (8, 12 or 20)
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-high reset; aborts any block in progress
//   start      - request one keystream block; only looked at in IDLE
//   key_in     - 256-bit key, word i = key_in[32i+31:32i]
//   nonce_in   - 96-bit nonce, word j = nonce_in[32j+31:32j]
//   counter_in - 32-bit block counter
//   busy       - high from the cycle after start is taken until word 15 transfers
//   stream     - keystream word stream (master side)
//
// Optional feature (macro CHACHA_CTR_AUTOINC_EN):
//   Compiles in an internal block counter. The first start after reset uses
//   counter_in; every later start uses the previous block's counter + 1
//   (wrapping) and ignores counter_in. Without the macro every start uses
//   counter_in and no counter register exists.
module chacha_block_ctrl #(
    parameter int unsigned ROUNDS = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [255:0]               key_in,
    input  logic [95:0]                nonce_in,
    input  logic [31:0]                counter_in,
    output logic                       busy,
    chacha_block_ctrl_if.master        stream
);

    localparam int unsigned RndCycles = 4 * ROUNDS;
    localparam int unsigned CntW      = $clog2(RndCycles);

    typedef enum logic [1:0] {
        StIdle,
        StRound,
        StFinal,
        StOut
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       work_q [16];
    logic [31:0]       work_d [16];
    logic [31:0]       init_q [16];
    logic [31:0]       init_d [16];
    logic [2:0]        q_q, q_d;
    logic [CntW-1:0]   rnd_q, rnd_d;
    logic [3:0]        widx_q, widx_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [31:0]       out_data_q, out_data_d;

    // Counter value loaded into state word 12 on the start edge.
    logic [31:0]       blk_ctr;

`ifdef CHACHA_CTR_AUTOINC_EN
    logic [31:0]       ctr_q, ctr_d;
    logic              ctr_vld_q, ctr_vld_d;

    assign blk_ctr = ctr_vld_q ? (ctr_q + 32'd1) : counter_in;
`else
    assign blk_ctr = counter_in;
`endif

    // ------------------------------------------------------------------
    // Shared quarter-round datapath
    // ------------------------------------------------------------------
    // q = 0..3 selects column k = q; q = 4..7 selects the diagonal starting
    // at word k = q - 4, i.e. rows 1..3 rotated left by 1..3 positions.
    logic [1:0]  qk;
    logic [3:0]  ia, ib, ic, id;
    logic [31:0] qa, qb, qc, qd;
    logic [31:0] a1, b1, c1, d1, a2, b2, c2, d2;
    logic [31:0] tx0, tx1, tx2, tx3;

    always_comb begin
        qk = q_q[1:0];
        ia = {2'b00, qk};
        ib = {2'b01, qk + (q_q[2] ? 2'd1 : 2'd0)};
        ic = {2'b10, qk + (q_q[2] ? 2'd2 : 2'd0)};
        id = {2'b11, qk + (q_q[2] ? 2'd3 : 2'd0)};

        a1  = work_q[ia] + work_q[ib];
        tx0 = work_q[id] ^ a1;
        d1  = {tx0[15:0], tx0[31:16]};
        c1  = work_q[ic] + d1;
        tx1 = work_q[ib] ^ c1;
        b1  = {tx1[19:0], tx1[31:20]};
        a2  = a1 + b1;
        tx2 = d1 ^ a2;
        d2  = {tx2[23:0], tx2[31:24]};
        c2  = c1 + d2;
        tx3 = b1 ^ c2;
        b2  = {tx3[24:0], tx3[31:25]};

        qa = a2;
        qb = b2;
        qc = c2;
        qd = d2;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        init_d      = init_q;
        q_d         = q_q;
        rnd_d       = rnd_q;
        widx_d      = widx_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
`ifdef CHACHA_CTR_AUTOINC_EN
        ctr_d       = ctr_q;
        ctr_vld_d   = ctr_vld_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    init_d[0] = 32'h61707865;
                    init_d[1] = 32'h3320646e;
                    init_d[2] = 32'h79622d32;
                    init_d[3] = 32'h6b206574;
                    for (int i = 0; i < 8; i++) begin
                        init_d[4 + i] = key_in[32 * i +: 32];
                    end
                    init_d[12] = blk_ctr;
                    for (int j = 0; j < 3; j++) begin
                        init_d[13 + j] = nonce_in[32 * j +: 32];
                    end
                    work_d  = init_d;
                    q_d     = 3'd0;
                    rnd_d   = '0;
                    widx_d  = 4'd0;
                    state_d = StRound;
`ifdef CHACHA_CTR_AUTOINC_EN
                    ctr_d     = blk_ctr;
                    ctr_vld_d = 1'b1;
`endif
                end
            end

            StRound: begin
                work_d[ia] = qa;
                work_d[ib] = qb;
                work_d[ic] = qc;
                work_d[id] = qd;
                q_d        = q_q + 3'd1;
                if (rnd_q == CntW'(RndCycles - 1)) begin
                    rnd_d   = '0;
                    state_d = StFinal;
                end else begin
                    rnd_d = rnd_q + 1'b1;
                end
            end

            StFinal: begin
                for (int i = 0; i < 16; i++) begin
                    work_d[i] = work_q[i] + init_q[i];
                end
                widx_d  = 4'd0;
                state_d = StOut;
            end

            StOut: begin
                // First OUT cycle loads word 0 into the output register; the
                // register then only changes on a transfer, so it holds while
                // the consumer stalls.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = work_q[widx_q];
                    out_last_d  = (widx_q == 4'd15);
                end else if (stream.out_ready) begin
                    if (widx_q == 4'd15) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        out_data_d  = 32'd0;
                        widx_d      = 4'd0;
                        state_d     = StIdle;
                    end else begin
                        widx_d     = widx_q + 4'd1;
                        out_data_d = work_q[widx_q + 4'd1];
                        out_last_d = (widx_q == 4'd14);
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            for (int i = 0; i < 16; i++) begin
                work_q[i] <= 32'd0;
                init_q[i] <= 32'd0;
            end
            q_q         <= 3'd0;
            rnd_q       <= '0;
            widx_q      <= 4'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            init_q      <= init_d;
            q_q         <= q_d;
            rnd_q       <= rnd_d;
            widx_q      <= widx_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

`ifdef CHACHA_CTR_AUTOINC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctr_q     <= 32'd0;
            ctr_vld_q <= 1'b0;
        end else begin
            ctr_q     <= ctr_d;
            ctr_vld_q <= ctr_vld_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy             = (state_q != StIdle);
    assign stream.out_valid = out_valid_q;
    assign stream.out_data  = out_data_q;
    assign stream.out_last  = out_last_q;

endmodule
